// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus arbiter.
// Holds default result widths, the queued result entry type and the
// requester index map (alu1, alu2, ld1, ld2).
package cdb_pkg;

  localparam int CDB_TAG_W  = 5;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;

  localparam int REQ_ALU1 = 0;
  localparam int REQ_ALU2 = 1;
  localparam int REQ_LD1  = 2;
  localparam int REQ_LD2  = 3;

endpackage

// File: rtl/cdb_hold_fifo.sv
// Per-requester holding queue: DEPTH entries of cdb_entry_t with a
// registered occupancy count. Callers only push when count < DEPTH and only
// pop when count > 0; flush empties the queue and wins over push/pop.
module cdb_hold_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  cdb_entry_t    push_entry,
  input  logic          pop,
  output cdb_entry_t    head,
  output logic [CW-1:0] count
);

  cdb_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy tracking; flush drops everything held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr] <= push_entry;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving NUM_BUS common data buses from NUM_REQ result
// producers, each buffered by a small holding queue. Bus outputs are
// registered. Optional build macro: CDB_BYPASS_EN lets a result arriving at
// an empty queue compete for a bus in the same cycle it is presented.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_BUS = 2,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int DEPTH   = 2,
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_BUS-1:0]        bus_valid,
  output logic [NUM_BUS*TAG_W-1:0]  bus_tag,
  output logic [NUM_BUS*DATA_W-1:0] bus_data,
  output logic [NUM_BUS*SW-1:0]     bus_src
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = SW + 1;

  logic [CW-1:0]     w_count    [NUM_REQ];
  cdb_entry_t        w_head     [NUM_REQ];
  cdb_entry_t        w_in_entry [NUM_REQ];
  logic [NUM_REQ-1:0] w_accept;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_from_in;
  logic [NUM_REQ-1:0] w_gnt_req;
  logic [SW-1:0]     w_pos      [NUM_REQ];
  logic [RW-1:0]     w_rank     [NUM_REQ];
  logic [NUM_BUS-1:0] w_gnt;
  logic [SW-1:0]     w_gnt_src  [NUM_BUS];
  cdb_entry_t        w_gnt_entry[NUM_BUS];
  logic [SW-1:0]     w_rr_next;
  logic [SW-1:0]     w_last_pos;

  logic [SW-1:0]     r_rr_ptr;
  logic [NUM_BUS-1:0] r_bus_valid;
  logic [TAG_W-1:0]  r_bus_tag  [NUM_BUS];
  logic [DATA_W-1:0] r_bus_data [NUM_BUS];
  logic [SW-1:0]     r_bus_src  [NUM_BUS];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    // Ready looks only at registered occupancy, so grant never feeds ready.
    assign req_ready[gi]  = (w_count[gi] < CW'(DEPTH)) && !flush;
    assign w_accept[gi]   = req_valid[gi] && req_ready[gi];
    assign w_in_entry[gi] = '{tag:  req_tag[gi*TAG_W +: TAG_W],
                              data: req_data[gi*DATA_W +: DATA_W]};
`ifdef CDB_BYPASS_EN
    assign w_from_in[gi]  = (w_count[gi] == '0);
    assign w_cand[gi]     = (w_count[gi] != '0) || w_accept[gi];
`else
    assign w_from_in[gi]  = 1'b0;
    assign w_cand[gi]     = (w_count[gi] != '0);
`endif

    cdb_hold_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .push       (w_accept[gi] && !(w_gnt_req[gi] && w_from_in[gi])),
      .push_entry (w_in_entry[gi]),
      .pop        (w_gnt_req[gi] && !w_from_in[gi]),
      .head       (w_head[gi]),
      .count      (w_count[gi])
    );
  end

  // Round-robin grant: rank each candidate by its scan distance from
  // rr_ptr; the NUM_BUS lowest ranks win and rank selects the bus.
  always_comb begin
    w_gnt_req  = '0;
    w_gnt      = '0;
    w_rr_next  = r_rr_ptr;
    w_last_pos = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      w_gnt_src[b]   = '0;
      w_gnt_entry[b] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pos[i]  = SW'((i + NUM_REQ - int'(r_rr_ptr)) % NUM_REQ);
      w_rank[i] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (w_cand[j] && (w_pos[j] < w_pos[i])) w_rank[i] = w_rank[i] + 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_req[i] = w_cand[i] && (w_rank[i] < RW'(NUM_BUS));
      if (w_gnt_req[i]) begin
        for (int b = 0; b < NUM_BUS; b++) begin
          if (w_rank[i] == RW'(b)) begin
            w_gnt[b]       = 1'b1;
            w_gnt_src[b]   = SW'(i);
            w_gnt_entry[b] = w_from_in[i] ? w_in_entry[i] : w_head[i];
          end
        end
        if (w_pos[i] >= w_last_pos) begin
          w_last_pos = w_pos[i];
          w_rr_next  = SW'((i + 1) % NUM_REQ);
        end
      end
    end
  end

  // Bus registers and rotation pointer; unused buses keep their last payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr    <= '0;
      r_bus_valid <= '0;
      for (int b = 0; b < NUM_BUS; b++) begin
        r_bus_tag[b]  <= '0;
        r_bus_data[b] <= '0;
        r_bus_src[b]  <= '0;
      end
    end else if (flush) begin
      r_rr_ptr    <= '0;
      r_bus_valid <= '0;
    end else begin
      r_rr_ptr    <= w_rr_next;
      r_bus_valid <= w_gnt;
      for (int b = 0; b < NUM_BUS; b++) begin
        if (w_gnt[b]) begin
          r_bus_tag[b]  <= w_gnt_entry[b].tag;
          r_bus_data[b] <= w_gnt_entry[b].data;
          r_bus_src[b]  <= w_gnt_src[b];
        end
      end
    end
  end

  assign bus_valid = r_bus_valid;
  for (genvar gb = 0; gb < NUM_BUS; gb++) begin : g_bus
    assign bus_tag[gb*TAG_W +: TAG_W]    = r_bus_tag[gb];
    assign bus_data[gb*DATA_W +: DATA_W] = r_bus_data[gb];
    assign bus_src[gb*SW +: SW]          = r_bus_src[gb];
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NR = 4;
  localparam int NB = 2;
  localparam int TW = CDB_TAG_W;
  localparam int DW = CDB_DATA_W;
  localparam int DP = 2;
  localparam int SW = 2;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*TW-1:0]  req_tag;
  logic [NR*DW-1:0]  req_data;
  logic [NB-1:0]     bus_valid;
  logic [NB*TW-1:0]  bus_tag;
  logic [NB*DW-1:0]  bus_data;
  logic [NB*SW-1:0]  bus_src;

  cdb_arbiter #(.NUM_REQ(NR), .NUM_BUS(NB), .TAG_W(TW), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .bus_valid (bus_valid),
    .bus_tag   (bus_tag),
    .bus_data  (bus_data),
    .bus_src   (bus_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q [NR][$];
  int            rr;
  logic [NB-1:0] m_valid;
  logic [NB*TW-1:0] m_tag;
  logic [NB*DW-1:0] m_data;
  logic [NB*SW-1:0] m_src;
  logic [NR-1:0] last_acc;
  int            n_vec;
  int            n_err;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] model_ready();
    logic [NR-1:0] r;
    for (int i = 0; i < NR; i++) r[i] = (q[i].size() < DP) && !flush;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) q[i].delete();
    rr = 0;
    m_valid = '0;
    m_tag = '0;
    m_data = '0;
    m_src = '0;
  endtask

  // One clock edge of the reference: accept, scan from rr, grant, push.
  task automatic model_edge();
    logic [NR-1:0] acc;
    logic [NR-1:0] byp;
    int nb;
    int last;
    acc = model_ready() & req_valid;
    last_acc = acc;
    byp = '0;
    if (flush) begin
      for (int i = 0; i < NR; i++) q[i].delete();
      m_valid = '0;
      rr = 0;
      return;
    end
    nb = 0;
    last = -1;
    m_valid = '0;
    for (int k = 0; k < NR; k++) begin
      int i;
      bit g;
      ent_t e;
      i = (rr + k) % NR;
      g = 0;
      if (nb < NB) begin
        if (q[i].size() > 0) begin
          e = q[i].pop_front();
          g = 1;
        end
`ifdef CDB_BYPASS_EN
        else if (acc[i]) begin
          e.tag = req_tag[i*TW +: TW];
          e.data = req_data[i*DW +: DW];
          byp[i] = 1'b1;
          g = 1;
        end
`endif
      end
      if (g) begin
        m_valid[nb] = 1'b1;
        m_tag[nb*TW +: TW] = e.tag;
        m_data[nb*DW +: DW] = e.data;
        m_src[nb*SW +: SW] = SW'(i);
        last = i;
        nb++;
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (acc[i] && !byp[i]) begin
        ent_t e;
        e.tag = req_tag[i*TW +: TW];
        e.data = req_data[i*DW +: DW];
        q[i].push_back(e);
      end
    end
    if (last >= 0) rr = (last + 1) % NR;
  endtask

  task automatic check_bus();
    check("bus_valid", bus_valid, m_valid);
    check("bus_tag", bus_tag, m_tag);
    check("bus_data", bus_data, m_data);
    check("bus_src", bus_src, m_src);
  endtask

  // Called at posedge+1: drive, check ready, take the edge, check buses.
  task automatic step(input logic [NR-1:0] v, input logic [NR*TW-1:0] t,
                      input logic [NR*DW-1:0] d, input logic fl);
    req_valid = v;
    req_tag = t;
    req_data = d;
    flush = fl;
    #1;
    check("req_ready", req_ready, model_ready());
    @(posedge clk);
    model_edge();
    #1;
    check_bus();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step('0, '0, '0, 1'b0);
  endtask

  initial begin
    int j;
    logic saw;
    logic [NB-1:0] seen_valid;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    flush = 1'b0;
    req_valid = '0;
    req_tag = '0;
    req_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 4'hF);
    check_bus();
    rst = 1'b1;

    // Single alu1 result, tag 5 / data 0x11.
    step(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h0, 32'h11}, 1'b0);
`ifndef CDB_BYPASS_EN
    check("t1_early", bus_valid, 2'b00);
    step('0, '0, '0, 1'b0);
`endif
    check("t1_valid", bus_valid, 2'b01);
    check("t1_tag", bus_tag[TW-1:0], 5);
    check("t1_data", bus_data[DW-1:0], 32'h11);
    check("t1_src", bus_src[SW-1:0], REQ_ALU1);
    idle(2);

    // All four push at once from rr_ptr = 0.
    step('0, '0, '0, 1'b1);
    step(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1},
         {32'hD4, 32'hD3, 32'hD2, 32'hD1}, 1'b0);
`ifndef CDB_BYPASS_EN
    step('0, '0, '0, 1'b0);
`endif
    check("t2_src01", bus_src, {2'(REQ_ALU2), 2'(REQ_ALU1)});
    step('0, '0, '0, 1'b0);
    check("t2_src23", bus_src, {2'(REQ_LD2), 2'(REQ_LD1)});
    check("t2_valid", bus_valid, 2'b11);
    idle(2);

    // ld1 streams tags 7, 8, 9 while both ALUs keep the buses busy.
    j = 0;
    saw = 1'b0;
    for (int c = 0; c < 14; c++) begin
      logic [NR-1:0] v;
      v = 4'b0011 | ((j < 3) ? 4'b0100 : 4'b0000);
      step(v, {5'd0, 5'(7 + j), 5'(c), 5'(20 + c)},
           {32'h0, 32'(32'h700 + j), 32'(c), 32'(c + 100)}, 1'b0);
      if (v[REQ_LD1] && !last_acc[REQ_LD1]) saw = 1'b1;
      if (last_acc[REQ_LD1]) j++;
    end
    check("t3_pushed", j, 3);
`ifndef CDB_BYPASS_EN
    check("t3_ready_drop", saw, 1'b1);
`endif
    idle(6);

    // Only ld2 pending at rr_ptr = 0.
    step('0, '0, '0, 1'b1);
    step(4'b1000, {5'd3, 15'd0}, {32'h33, 96'h0}, 1'b0);
`ifndef CDB_BYPASS_EN
    step('0, '0, '0, 1'b0);
`endif
    check("t4_valid", bus_valid, 2'b01);
    check("t4_src", bus_src[SW-1:0], REQ_LD2);
    // rr_ptr wrapped to 0: alu1 and ld2 together must grant alu1 first.
    step(4'b1001, {5'd12, 10'd0, 5'd11}, {32'hB2, 64'h0, 32'hB1}, 1'b0);
    idle(3);

    // Flush with three results queued: nothing stale may surface later.
    step(4'b0111, {5'd0, 5'd23, 5'd22, 5'd21}, {32'h0, 32'hE3, 32'hE2, 32'hE1}, 1'b0);
    step(4'b1111, {5'd31, 5'd30, 5'd29, 5'd28}, {32'hF4, 32'hF3, 32'hF2, 32'hF1}, 1'b1);
    check("t5_valid", bus_valid, 2'b00);
    seen_valid = '0;
    for (int c = 0; c < 4; c++) begin
      step('0, '0, '0, 1'b0);
      seen_valid |= bus_valid;
    end
    check("t5_no_stale", seen_valid, 2'b00);

    // Asynchronous reset in the middle of a burst.
    step(4'b1111, {5'd1, 5'd2, 5'd3, 5'd4}, {32'hA1, 32'hA2, 32'hA3, 32'hA4}, 1'b0);
    step(4'b1111, {5'd5, 5'd6, 5'd7, 5'd8}, {32'hA5, 32'hA6, 32'hA7, 32'hA8}, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("t6_valid", bus_valid, 2'b00);
    check("t6_tag", bus_tag, '0);
    check("t6_ready", req_ready, 4'hF);
    req_valid = '0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    check_bus();
    idle(3);
    step(4'b0100, {5'd0, 5'd17, 10'd0}, {32'h0, 32'h1717, 64'h0}, 1'b0);
    idle(3);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      step(NR'($urandom), NR*TW'({$urandom, $urandom}),
           {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 19) == 0));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
